// File: rtl/mmmu_rvtu_rr_arb_pkg.sv
// Shared types for the RVTU round-robin arbiter: FSM state encoding and requester ID width.
package mmmu_types;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WB
    } arb_state_t;

    localparam int NUM_RVTU_PAIRS = 4;

    typedef logic [$clog2(NUM_RVTU_PAIRS)-1:0] rvtu_id_t;

endpackage

// File: rtl/mmmu_rvtu_rr_arb_if.sv
// Requester-side and arbiter-port-side signal bundle for mmmu_rvtu_rr_arb.
interface mmmu_rvtu_rr_arb_if #(
    parameter int NUM_PAIRS = 4
);
    logic [NUM_PAIRS-1:0]        req_read;
    logic [NUM_PAIRS-1:0]        req_write;
    logic [NUM_PAIRS-1:0][31:0]  req_addr;
    logic [NUM_PAIRS-1:0][31:0]  req_wdata;
    logic [NUM_PAIRS-1:0]        req_ack;
    logic [NUM_PAIRS-1:0]        req_wb_done;
    logic [NUM_PAIRS-1:0]        req_rdata_vld;
    logic [31:0]                 req_rdata;
    logic                        dfp_read;
    logic                        dfp_write;
    logic [31:0]                 dfp_addr;
    logic [31:0]                 dfp_wdata;
    logic                        dfp_ack;
    logic                        wb_fin;
    logic                        rd_resp_vld;
    logic [31:0]                 rd_resp_data;
    logic                        rd_resp_last;
    logic                        err_orphan_resp;

    // The arbiter itself is the slave; requesters plus the arbiter port form the master side.
    modport slave (
        input  req_read, req_write, req_addr, req_wdata,
        input  dfp_ack, wb_fin, rd_resp_vld, rd_resp_data, rd_resp_last,
        output req_ack, req_wb_done, req_rdata_vld, req_rdata,
        output dfp_read, dfp_write, dfp_addr, dfp_wdata, err_orphan_resp
    );

    modport master (
        output req_read, req_write, req_addr, req_wdata,
        output dfp_ack, wb_fin, rd_resp_vld, rd_resp_data, rd_resp_last,
        input  req_ack, req_wb_done, req_rdata_vld, req_rdata,
        input  dfp_read, dfp_write, dfp_addr, dfp_wdata, err_orphan_resp
    );
endinterface

// File: rtl/mmmu_rvtu_rr_arb_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads; pointers carry an extra wrap bit.
module mmmu_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]             wr_ptr_q, wr_ptr_d;
    logic [AW:0]             rd_ptr_q, rd_ptr_d;
    logic [DEPTH-1:0][W-1:0] mem_q, mem_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = din;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/mmmu_rvtu_rr_arb.sv
// Round-robin scheduler sharing one RVTU-pair port among NUM_PAIRS requesters,
// with in-order tag tracking so read-response beats return to their issuer.
module mmmu_rvtu_rr_arb
    import mmmu_types::*;
#(
    parameter int NUM_PAIRS = NUM_RVTU_PAIRS,
    parameter int TAG_DEPTH = 4
) (
    input logic               clk,
    input logic               rst,
    mmmu_rvtu_rr_arb_if.slave bus
);
    localparam int IDW = $clog2(NUM_PAIRS);

    arb_state_t          state_q, state_d;
    logic [IDW-1:0]      owner_q, owner_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic                is_wr_q, is_wr_d;
    logic [31:0]         addr_q, addr_d;
    logic                err_q, err_d;

    logic [NUM_PAIRS-1:0] eligible;
    logic                 found;
    logic [IDW-1:0]       sel;
    logic [IDW-1:0]       cand;
    logic [NUM_PAIRS-1:0] ack_vec;
    logic [NUM_PAIRS-1:0] done_vec;
    logic [31:0]          wdata_o;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic [IDW-1:0]       head;

    // Reads are masked while the tag FIFO is full so a push can never overflow it.
    assign eligible = bus.req_write | (bus.req_read & {NUM_PAIRS{~fifo_full}});

    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            cand = rr_ptr_q + IDW'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        rr_ptr_d = rr_ptr_q;
        ack_vec  = '0;
        done_vec = '0;
        wdata_o  = '0;
        push     = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    owner_d = sel;
                    addr_d  = bus.req_addr[sel];
                    is_wr_d = bus.req_write[sel];
                    state_d = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (bus.dfp_ack) begin
                    ack_vec[owner_q] = 1'b1;
                    rr_ptr_d         = owner_q + IDW'(1);
                    if (is_wr_q) begin
                        state_d = ARB_WB;
                    end else begin
                        push    = 1'b1;
                        state_d = ARB_IDLE;
                    end
                end
            end
            ARB_WB: begin
                wdata_o = bus.req_wdata[owner_q];
                if (bus.wb_fin) begin
                    done_vec[owner_q] = 1'b1;
                    state_d           = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign pop   = bus.rd_resp_vld && bus.rd_resp_last && !fifo_empty;
    assign err_d = err_q | (bus.rd_resp_vld & fifo_empty);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
        end
    end

    mmmu_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .W     (IDW)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (owner_q),
        .dout  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // A reset abandons the in-flight transaction, so the handshake pulses are suppressed too.
    assign bus.req_ack         = rst ? '0 : ack_vec;
    assign bus.req_wb_done     = rst ? '0 : done_vec;
    assign bus.req_rdata_vld   = (bus.rd_resp_vld && !fifo_empty)
                                 ? ({{(NUM_PAIRS-1){1'b0}}, 1'b1} << head) : '0;
    assign bus.req_rdata       = bus.rd_resp_data;
    assign bus.dfp_read        = (state_q == ARB_REQ) && !is_wr_q;
    assign bus.dfp_write       = (state_q == ARB_REQ) && is_wr_q;
    assign bus.dfp_addr        = addr_q;
    assign bus.dfp_wdata       = wdata_o;
    assign bus.err_orphan_resp = err_q;

endmodule
